mips_mc_ctrl: RTL and testbench

- Multi-cycle MIPS control FSM. It is the command-issuing end of the ALU interface.
- Sequences fetch, decode, execute, memory and writeback for each instruction.
- Each cycle it drives the 4-bit ALU operation code, operand-select muxes, memory strobes and register/PC write enables.
- Sits between the instruction register/memory port and the datapath (ALU, register file, PC).

---
 rtl/mips_pkg.sv | 16 +
 rtl/alu_op_decode.sv | 40 ++++
 rtl/mips_mc_ctrl.sv | 150 +++++++++++++++
 tb/tb_mips_mc_ctrl.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared ALU codes, opcode/funct constants and control FSM state encoding
package mips_pkg;
  localparam logic [3:0] ALU_AND  = 4'b0000, ALU_OR   = 4'b0001, ALU_ADD  = 4'b0010, ALU_ADDU = 4'b0011;
  localparam logic [3:0] ALU_SUBU = 4'b0100, ALU_XOR  = 4'b0101, ALU_SUB  = 4'b0110, ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLL  = 4'b1000, ALU_SRL  = 4'b1001, ALU_ANDI = 4'b1010, ALU_ORI  = 4'b1011;
  localparam logic [3:0] ALU_NOR  = 4'b1100;
  localparam logic [5:0] OP_RTYPE = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011, OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J = 6'b000010, OP_ADDI = 6'b001000, OP_ADDIU = 6'b001001, OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI = 6'b001101, OP_SLTI = 6'b001010;
  localparam logic [5:0] F_ADD = 6'b100000, F_ADDU = 6'b100001, F_SUB = 6'b100010, F_SUBU = 6'b100011;
  localparam logic [5:0] F_AND = 6'b100100, F_OR = 6'b100101, F_XOR = 6'b100110, F_NOR = 6'b100111;
  localparam logic [5:0] F_SLT = 6'b101010, F_SLL = 6'b000000, F_SRL = 6'b000010;
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPE_EX, RTYPE_WB, BEQ_EX, IMM_EX, IMM_WB, JUMP, ILLEGAL
  } state_t;
endpackage

// File: rtl/alu_op_decode.sv
// alu_op_decode: maps opcode/funct to the instruction's ALU code, immediate extension and legality
module alu_op_decode
  import mips_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [3:0] alu_ctrl,
  output logic       ext_op,
  output logic       legal
);
  always_comb begin
    alu_ctrl = ALU_ADDU;
    ext_op   = 1'b1;
    legal    = 1'b1;
    case (opcode)
      OP_RTYPE:
        case (funct)
          F_ADD:   alu_ctrl = ALU_ADD;
          F_ADDU:  alu_ctrl = ALU_ADDU;
          F_SUB:   alu_ctrl = ALU_SUB;
          F_SUBU:  alu_ctrl = ALU_SUBU;
          F_AND:   alu_ctrl = ALU_AND;
          F_OR:    alu_ctrl = ALU_OR;
          F_XOR:   alu_ctrl = ALU_XOR;
          F_NOR:   alu_ctrl = ALU_NOR;
          F_SLT:   alu_ctrl = ALU_SLT;
          F_SLL:   alu_ctrl = ALU_SLL;
          F_SRL:   alu_ctrl = ALU_SRL;
          default: legal = 1'b0;
        endcase
      OP_ADDI:  alu_ctrl = ALU_ADD;
      OP_ADDIU: alu_ctrl = ALU_ADDU;
      OP_SLTI:  alu_ctrl = ALU_SLT;
      OP_ANDI:  begin alu_ctrl = ALU_ANDI; ext_op = 1'b0; end
      OP_ORI:   begin alu_ctrl = ALU_ORI;  ext_op = 1'b0; end
      OP_LW, OP_SW, OP_BEQ, OP_J: ;
      default:  legal = 1'b0;
    endcase
  end
endmodule

// File: rtl/mips_mc_ctrl.sv
// mips_mc_ctrl: multi-cycle MIPS control FSM (opcode/funct/zero/mem_ready in; ALU, mux, strobe, write-enable, retire outputs)
module mips_mc_ctrl
  import mips_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic [3:0]       ALUControl,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic             ExtOp,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             RegWrite,
  output logic             RegDst,
  output logic             MemtoReg,
  output logic [1:0]       PCSource,
  output logic             illegal,
  output logic             instr_done,
  output logic [CNT_W-1:0] retired
);
  state_t           state_q, state_d;
  logic [CNT_W-1:0] retired_q;
  logic [3:0]       dec_alu;
  logic             dec_ext, dec_legal;
  logic             ir_w, pc_w, mem_w, reg_w, done, ill;
  alu_op_decode u_dec (.opcode(opcode), .funct(funct), .alu_ctrl(dec_alu), .ext_op(dec_ext), .legal(dec_legal));
  always_comb begin
    state_d    = state_q;
    ALUControl = 4'b0000;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ExtOp      = 1'b0;
    IorD       = 1'b0;
    MemRead    = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    PCSource   = 2'b00;
    ir_w       = 1'b0;
    pc_w       = 1'b0;
    mem_w      = 1'b0;
    reg_w      = 1'b0;
    done       = 1'b0;
    ill        = 1'b0;
    case (state_q)
      FETCH: begin
        MemRead    = 1'b1;
        ALUSrcB    = 2'b01;
        ALUControl = ALU_ADDU;
        ir_w       = mem_ready;
        pc_w       = mem_ready;
        state_d    = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        ALUSrcB    = 2'b11;
        ExtOp      = 1'b1;
        ALUControl = ALU_ADDU;
        state_d    = !dec_legal ? ILLEGAL :
                     opcode == OP_RTYPE ? RTYPE_EX :
                     (opcode == OP_LW || opcode == OP_SW) ? MEMADR :
                     opcode == OP_BEQ ? BEQ_EX :
                     opcode == OP_J ? JUMP : IMM_EX;
      end
      MEMADR: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        ExtOp      = 1'b1;
        ALUControl = ALU_ADDU;
        state_d    = opcode == OP_LW ? MEMRD : MEMWR;
      end
      MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        state_d = mem_ready ? MEMWB : MEMRD;
      end
      MEMWB: begin
        reg_w    = 1'b1;
        MemtoReg = 1'b1;
        done     = 1'b1;
        state_d  = FETCH;
      end
      MEMWR: begin
        mem_w   = 1'b1;
        IorD    = 1'b1;
        done    = mem_ready;
        state_d = mem_ready ? FETCH : MEMWR;
      end
      RTYPE_EX, RTYPE_WB: begin
        ALUSrcA    = 1'b1;
        ALUControl = dec_alu;
        reg_w      = state_q == RTYPE_WB;
        RegDst     = state_q == RTYPE_WB;
        done       = state_q == RTYPE_WB;
        state_d    = state_q == RTYPE_WB ? FETCH : RTYPE_WB;
      end
      BEQ_EX: begin
        ALUSrcA    = 1'b1;
        ALUControl = ALU_SUBU;
        PCSource   = 2'b01;
        pc_w       = zero;
        done       = 1'b1;
        state_d    = FETCH;
      end
      IMM_EX, IMM_WB: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        ExtOp      = dec_ext;
        ALUControl = dec_alu;
        reg_w      = state_q == IMM_WB;
        done       = state_q == IMM_WB;
        state_d    = state_q == IMM_WB ? FETCH : IMM_WB;
      end
      JUMP: begin
        PCSource = 2'b10;
        pc_w     = 1'b1;
        done     = 1'b1;
        state_d  = FETCH;
      end
      ILLEGAL: begin
        ill     = 1'b1;
        state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end
  assign IRWrite    = ir_w & ~reset;
  assign PCWrite    = pc_w & ~reset;
  assign MemWrite   = mem_w & ~reset;
  assign RegWrite   = reg_w & ~reset;
  assign instr_done = done & ~reset;
  assign illegal    = ill & ~reset;
  assign retired    = retired_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= FETCH;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= instr_done ? retired_q + CNT_W'(1) : retired_q;
    end
  end
endmodule

// File: tb/tb_mips_mc_ctrl.sv
// tb_mips_mc_ctrl: directed checks of the multi-cycle control FSM with a 4-bit retire counter
module tb_mips_mc_ctrl;
  logic       clk = 1'b0, reset = 1'b1, zero = 1'b0, mem_ready = 1'b1;
  logic [5:0] opcode = 6'b0, funct = 6'b0;
  logic [3:0] ALUControl;
  logic       ALUSrcA, ExtOp, IorD, MemRead, MemWrite, IRWrite, PCWrite, RegWrite, RegDst, MemtoReg;
  logic       illegal, instr_done;
  logic [1:0] ALUSrcB, PCSource;
  logic [3:0] retired;
  int         n_cmp = 0, n_bad = 0;
  mips_mc_ctrl #(.CNT_W(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .ALUControl(ALUControl), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ExtOp(ExtOp), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .PCSource(PCSource), .illegal(illegal),
    .instr_done(instr_done), .retired(retired)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic nxt;
    @(posedge clk);
    #1;
  endtask
  initial begin
    nxt;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset_wr", {IRWrite, PCWrite, MemWrite, RegWrite, instr_done, illegal}, 6'b0);
      nxt;
    end
    reset = 1'b0;
    funct = 6'b100000;
    @(negedge clk);
    chk("fetch_rd", {MemRead, IorD, ALUControl, ALUSrcB, IRWrite, PCWrite}, {2'b10, 4'b0011, 2'b01, 2'b11});
    chk("retired0", retired, 0);
    nxt;
    @(negedge clk);
    chk("add_dec", {ALUSrcA, ALUSrcB, ExtOp, ALUControl}, {1'b0, 2'b11, 1'b1, 4'b0011});
    nxt;
    @(negedge clk);
    chk("add_ex", {ALUSrcA, ALUSrcB, ALUControl, RegWrite, instr_done}, {1'b1, 2'b00, 4'b0010, 2'b00});
    nxt;
    @(negedge clk);
    chk("add_wb", {ALUControl, RegWrite, RegDst, instr_done}, {4'b0010, 3'b111});
    nxt;
    @(negedge clk);
    chk("add_ret", retired, 1);
    opcode = 6'b100011;
    nxt;
    nxt;
    @(negedge clk);
    chk("lw_adr", {ALUSrcA, ALUSrcB, ExtOp, ALUControl}, {1'b1, 2'b10, 1'b1, 4'b0011});
    nxt;
    for (int i = 0; i < 3; i++) begin
      mem_ready = (i == 2);
      @(negedge clk);
      chk("lw_rd", {MemRead, IorD, RegWrite, instr_done}, 4'b1100);
      nxt;
    end
    @(negedge clk);
    chk("lw_wb", {MemtoReg, RegWrite, RegDst, instr_done}, 4'b1101);
    nxt;
    @(negedge clk);
    chk("lw_ret", {MemRead, retired}, {1'b1, 4'd2});
    opcode = 6'b000100;
    zero = 1'b1;
    nxt;
    nxt;
    @(negedge clk);
    chk("beq_t", {PCWrite, PCSource, ALUControl, instr_done}, {3'b101, 4'b0100, 1'b1});
    nxt;
    zero = 1'b0;
    nxt;
    nxt;
    @(negedge clk);
    chk("beq_nt", {PCWrite, PCSource, instr_done}, 4'b0011);
    nxt;
    @(negedge clk);
    chk("beq_ret", retired, 4);
    opcode = 6'b001101;
    nxt;
    nxt;
    @(negedge clk);
    chk("ori_ex", {ALUControl, ExtOp, ALUSrcA, ALUSrcB, RegWrite}, {4'b1011, 1'b0, 1'b1, 2'b10, 1'b0});
    nxt;
    @(negedge clk);
    chk("ori_wb", {ALUControl, ExtOp, RegWrite, RegDst, instr_done}, {4'b1011, 4'b0101});
    nxt;
    opcode = 6'b111111;
    nxt;
    nxt;
    @(negedge clk);
    chk("ill", {illegal, instr_done, IRWrite, PCWrite, MemWrite, RegWrite}, 6'b100000);
    nxt;
    @(negedge clk);
    chk("ill_back", {illegal, MemRead, retired}, {2'b01, 4'd5});
    opcode = 6'b101011;
    nxt;
    nxt;
    nxt;
    @(negedge clk);
    chk("sw_wr", {MemWrite, IorD, instr_done}, 3'b111);
    nxt;
    @(negedge clk);
    chk("sw_ret", {MemRead, retired}, {1'b1, 4'd6});
    nxt;
    nxt;
    nxt;
    mem_ready = 1'b0;
    @(negedge clk);
    chk("sw_wait", {MemWrite, instr_done}, 2'b10);
    nxt;
    reset = 1'b1;
    @(negedge clk);
    chk("sw_rst", {MemWrite, instr_done}, 2'b00);
    nxt;
    reset = 1'b0;
    mem_ready = 1'b1;
    @(negedge clk);
    chk("rst_fetch", {MemRead, IorD, ALUControl, retired}, {2'b10, 4'b0011, 4'd0});
    opcode = 6'b000010;
    for (int i = 0; i < 16; i++) begin
      nxt;
      nxt;
      @(negedge clk);
      if (i == 0) chk("j_ex", {PCWrite, PCSource, instr_done}, 4'b1101);
      nxt;
      @(negedge clk);
      chk("j_ret", retired, (i + 1) % 16);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
